// File: rtl/clock_period_meter_if.sv
// ---------------------------------------------------------------------------
// clock_period_meter_if
//
// Purpose:
//   Result handshake between clock_period_meter and whatever consumes its
//   measurements. The meter drives each new result together with a valid
//   flag. The consumer acknowledges the result with meas_ready.
//
// Signals:
//   meas_div   [CNT_WIDTH] : last measured value, (half-period in cycles) - 1
//   meas_valid             : meas_div holds a result not yet consumed
//   meas_ready             : consumer accepts the current result
//
// Modports:
//   master : result producer (the meter)
//   slave  : result consumer
// ---------------------------------------------------------------------------
interface clock_period_meter_if #(
    parameter int unsigned CNT_WIDTH = 32
);

    logic [CNT_WIDTH-1:0] meas_div;
    logic                 meas_valid;
    logic                 meas_ready;

    // The meter owns the result and its valid flag. The consumer owns ready.
    modport master (
        output meas_div,
        output meas_valid,
        input  meas_ready
    );

    modport slave (
        input  meas_div,
        input  meas_valid,
        output meas_ready
    );

endinterface

// File: rtl/clock_period_meter.sv
// ---------------------------------------------------------------------------
// clock_period_meter
//
// Purpose:
//   Measures the half-period of a square wave in clk cycles. It reports the
//   result as the equivalent clock-divider setting, so a signal made by a
//   divider with value N reads back as N. Rising and falling input edges
//   both count as measuring edges.
//
// Parameters:
//   CNT_WIDTH : width of the cycle counter and of meas_div
//   TIMEOUT   : number of edge-free cycles before stalled asserts.
//               0 disables the timeout. It must fit in CNT_WIDTH bits.
//
// Ports:
//   clk      : system clock; the only clock in the block
//   rst_n    : synchronous active-low reset
//   sig_in   : signal to measure; may be asynchronous to clk
//   meas     : result handshake (meas_div / meas_valid / meas_ready)
//   overrun  : sticky flag; a result was overwritten before it was consumed
//   stalled  : no input edge seen for TIMEOUT cycles
// ---------------------------------------------------------------------------
module clock_period_meter #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sig_in,
    clock_period_meter_if.master meas,
    output logic                 overrun,
    output logic                 stalled
);

    typedef enum logic {
        IDLE,
        MEAS
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam bit                   TIMEOUT_EN   = (TIMEOUT != 0);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 hist_q;
    logic                 sigEdge;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 timeoutHit;

    state_t               state_q;
    logic [CNT_WIDTH-1:0] measDiv_q;
    logic                 measValid_q;
    logic                 overrun_q;
    logic                 stalled_q;

    // Bring sig_in into the clk domain through two flops. A third flop keeps
    // the previous synchronized level so that either polarity of transition
    // can be detected. Together these give the fixed latency: a transition
    // set up before edge n loads the result registers at edge n+2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign sigEdge = sync2_q ^ hist_q;

    // The cycle counter restarts on every detected edge. Otherwise it counts
    // up and sticks at all-ones rather than wrapping. A very slow input then
    // reads as the largest representable value and never aliases to a small
    // one. The counter runs in both states, so it also supplies the timeout
    // measurement.
    always_comb begin
        cnt_d = cnt_q;
        if (sigEdge) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The last edge-free cycle before the stall limit. This term is held at
    // zero when the timeout is disabled.
    assign timeoutHit = TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

    // Measurement FSM with registered outputs.
    //
    // IDLE holds no reference edge, so the first edge only arms the block.
    // In MEAS, every edge captures the count since the previous edge. The
    // count equals H-1 for edges H cycles apart, which is the divider
    // setting.
    //
    // A result always loads, even if the previous one was not consumed. If
    // that happens without a transfer on the same cycle, the overwrite is
    // recorded in the sticky overrun flag. When no edge arrives, a completed
    // transfer drops meas_valid.
    //
    // Reaching the stall limit without an edge drops the reference edge.
    // The edge that later ends the stall therefore only re-arms the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            measDiv_q   <= '0;
            measValid_q <= 1'b0;
            overrun_q   <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            if (measValid_q && meas.meas_ready) begin
                measValid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (sigEdge) begin
                        state_q   <= MEAS;
                        stalled_q <= 1'b0;
                    end
                end

                MEAS: begin
                    if (sigEdge) begin
                        measDiv_q   <= cnt_q;
                        measValid_q <= 1'b1;
                        stalled_q   <= 1'b0;
                        if (measValid_q && !meas.meas_ready) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (timeoutHit) begin
                        state_q   <= IDLE;
                        stalled_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign meas.meas_div   = measDiv_q;
    assign meas.meas_valid = measValid_q;
    assign overrun         = overrun_q;
    assign stalled         = stalled_q;

endmodule
